uart_rx: RTL

- UART receiver that deserialises the 11-bit frame produced by the team's UART transmitter.
- Frame format: start (0), WORD_LENGTH data bits LSB first, even parity bit (XOR of data), stop (1), then idle-high.
- Sits between the board RX pin and fabric logic.
- Delivers each received word on a valid/ready output interface, with parity, framing and overrun status.

---
 rtl/uart_rx.sv | 132 +++++++++++++
 1 files changed

// File: rtl/uart_rx.sv
// UART receiver: 2-flop input synchroniser, mid-bit sampling FSM and a valid/ready
// output holding register with parity, framing and overrun status.
module uart_rx #(
    parameter int CLOCKRATE   = 100000000,
    parameter int BAUD        = 115200,
    parameter int WORD_LENGTH = 8
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   UART_RX,
    output logic [WORD_LENGTH-1:0] rx_data,
    output logic                   rx_data_valid,
    input  logic                   rx_data_ready,
    output logic                   rx_parity_error,
    output logic                   rx_frame_error,
    output logic                   rx_overrun
);

    localparam int BIT_MAX  = CLOCKRATE / BAUD;
    localparam int HALF_MAX = BIT_MAX / 2;
    localparam int CNT_W    = $clog2(BIT_MAX);
    localparam int BCNT_W   = $clog2(WORD_LENGTH + 1);

    typedef enum logic [2:0] {
        IDLE, START, DATA, PARITY, STOP, BREAK
    } state_t;

    function automatic logic f_parity(input logic [WORD_LENGTH-1:0] v);
        return ^v;
    endfunction

    logic                   r_sync_p0;
    logic                   r_sync_p1;
    logic                   w_rx_s;
    state_t                 r_state;
    logic [CNT_W-1:0]       r_cnt;
    logic [BCNT_W-1:0]      r_bitcnt;
    logic [WORD_LENGTH-1:0] r_shift;
    logic                   r_par_err;
    logic                   w_tick;

    assign w_rx_s = r_sync_p1;
    // START only waits half a bit so every later tick lands mid-bit
    assign w_tick = (r_state == START) ? (r_cnt == CNT_W'(HALF_MAX - 1))
                                       : (r_cnt == CNT_W'(BIT_MAX - 1));

    // stage p0/p1: metastability synchroniser on the raw line
    always_ff @(posedge clk) begin
        if (reset) begin
            r_sync_p0 <= 1'b1;
            r_sync_p1 <= 1'b1;
        end else begin
            r_sync_p0 <= UART_RX;
            r_sync_p1 <= r_sync_p0;
        end
    end

    // frame FSM and output holding register
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state         <= IDLE;
            r_cnt           <= '0;
            r_bitcnt        <= '0;
            r_shift         <= '0;
            r_par_err       <= 1'b0;
            rx_data         <= '0;
            rx_data_valid   <= 1'b0;
            rx_parity_error <= 1'b0;
            rx_frame_error  <= 1'b0;
            rx_overrun      <= 1'b0;
        end else begin
            rx_overrun <= 1'b0;
            if (rx_data_valid && rx_data_ready)
                rx_data_valid <= 1'b0;

            if (r_state == IDLE || r_state == BREAK || w_tick)
                r_cnt <= '0;
            else
                r_cnt <= r_cnt + 1'b1;

            case (r_state)
                IDLE: begin
                    if (!w_rx_s)
                        r_state <= START;
                end
                START: begin
                    if (w_tick) begin
                        r_bitcnt <= '0;
                        r_state  <= w_rx_s ? IDLE : DATA;
                    end
                end
                DATA: begin
                    if (w_tick) begin
                        r_shift <= {w_rx_s, r_shift[WORD_LENGTH-1:1]};
                        if (r_bitcnt == BCNT_W'(WORD_LENGTH - 1)) begin
                            r_bitcnt <= '0;
                            r_state  <= PARITY;
                        end else begin
                            r_bitcnt <= r_bitcnt + 1'b1;
                        end
                    end
                end
                PARITY: begin
                    if (w_tick) begin
                        r_par_err <= w_rx_s ^ f_parity(r_shift);
                        r_state   <= STOP;
                    end
                end
                STOP: begin
                    if (w_tick) begin
                        r_state <= w_rx_s ? IDLE : BREAK;
                        // a word still held and not accepted this cycle wins; the new one is dropped
                        if (!rx_data_valid || rx_data_ready) begin
                            rx_data         <= r_shift;
                            rx_parity_error <= r_par_err;
                            rx_frame_error  <= ~w_rx_s;
                            rx_data_valid   <= 1'b1;
                        end else begin
                            rx_overrun <= 1'b1;
                        end
                    end
                end
                BREAK: begin
                    if (w_rx_s)
                        r_state <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

endmodule
